// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared types and constants for the memory-access / MEM-WB stage.
//   state_t     : access FSM states (IDLE, BUSY)
//   WORD_W      : datapath word width
//   REG_ADDR_W  : register-file address width
//   idx_width() : word-index width for a data memory of a given depth
//   cnt_width() : latency down-counter width for a given access latency
// ---------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Word-index width; clamped to 1 so a degenerate depth still yields a
  // legal vector width.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Down-counter width; a single-cycle memory still gets a 1-bit counter so
  // the declaration stays legal even though it is never used.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mem_wb_stage_data_mem.sv
// ---------------------------------------------------------------------------
// data_mem
// DEPTH x WORD_W data memory with one asynchronous read port and one
// synchronous write port.
//   clk   : write clock
//   we    : write enable, write happens on the rising edge
//   waddr : write word index
//   wdata : write data
//   raddr : read word index
//   rdata : read data (combinational, shows the pre-write contents)
// ---------------------------------------------------------------------------
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
);

  // Contents are deliberately not reset; software must initialise memory.
  logic [WORD_W-1:0] mem_array [DEPTH];

  assign rdata = mem_array[raddr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_array[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
// Memory-access stage plus MEM/WB pipeline register. Loads and stores go to
// a local data memory whose access occupies the stage for MEM_LAT cycles;
// while an access is in flight the stage stalls upstream and feeds bubbles
// into MEM/WB.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   Reg_w_in        : register-write enable from EX/MEM
//   Mem_to_reg_in   : load (write-back takes memory data)
//   Mem_w_in        : store enable
//   ALU_Result_in   : byte address for memory ops, result for ALU ops
//   RtData_in       : store data
//   RdAddr_in       : destination register
//   ISE_in          : instruction word (trace only)
//   stall           : combinational, upstream must hold while high
//   Reg_w_out .. ISE_out : MEM/WB register contents
//   Wb_Data         : combinational write-back / forwarding value
// ---------------------------------------------------------------------------
module mem_wb_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Reg_w_in,
  input  logic                  Mem_to_reg_in,
  input  logic                  Mem_w_in,
  input  logic [WORD_W-1:0]     ALU_Result_in,
  input  logic [WORD_W-1:0]     RtData_in,
  input  logic [REG_ADDR_W-1:0] RdAddr_in,
  input  logic [WORD_W-1:0]     ISE_in,
  output logic                  stall,
  output logic                  Reg_w_out,
  output logic                  Mem_to_reg_out,
  output logic [WORD_W-1:0]     Mem_Data_out,
  output logic [WORD_W-1:0]     ALU_Result_out,
  output logic [REG_ADDR_W-1:0] RdAddr_out,
  output logic [WORD_W-1:0]     ISE_out,
  output logic [WORD_W-1:0]     Wb_Data
);

  localparam int IDX_W = idx_width(DEPTH);
  localparam int CNT_W = cnt_width(MEM_LAT);
  // The IDLE cycle that launches an access counts as its first cycle, so
  // BUSY needs MEM_LAT-1 further cycles: counter runs MEM_LAT-2 .. 0.
  localparam logic [CNT_W-1:0] CNT_START =
    CNT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  // -------------------------------------------------------------------------
  // Addressing: word index only; byte offset and high bits are dropped so
  // the address wraps modulo DEPTH words.
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0]  word_idx;
  logic [WORD_W-1:0] rd_word;
  logic              unused_addr_bits;

  assign word_idx         = ALU_Result_in[IDX_W+1:2];
  assign unused_addr_bits = ^{ALU_Result_in[WORD_W-1:IDX_W+2], ALU_Result_in[1:0]};

  // -------------------------------------------------------------------------
  // Access FSM
  // -------------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             mem_op;
  logic             bubble;     // MEM/WB takes a bubble this edge
  logic             stall_raw;
  logic             mem_we;

  assign mem_op = Mem_w_in | Mem_to_reg_in;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall_raw  = 1'b0;
    bubble     = 1'b0;
    if (MEM_LAT > 1) begin
      case (state_reg)
        IDLE: begin
          if (mem_op) begin
            stall_raw  = 1'b1;
            bubble     = 1'b1;
            cnt_next   = CNT_START;
            state_next = BUSY;
          end
        end
        BUSY: begin
          if (cnt_reg != '0) begin
            stall_raw = 1'b1;
            bubble    = 1'b1;
            cnt_next  = cnt_reg - CNT_W'(1);
          end else begin
            // Access completes on this edge; MEM/WB loads the real result.
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Upstream is being reset along with this stage, so no hold is needed.
  assign stall = stall_raw & ~rst;

  // A store commits only on its completing edge, and never on a reset edge.
  assign mem_we = Mem_w_in & ~bubble & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Data memory
  // -------------------------------------------------------------------------
  data_mem #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_data_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (word_idx),
    .wdata (RtData_in),
    .raddr (word_idx),
    .rdata (rd_word)
  );

  // -------------------------------------------------------------------------
  // MEM/WB pipeline register
  // -------------------------------------------------------------------------
  logic                  reg_w_reg;
  logic                  mem_to_reg_reg;
  logic [WORD_W-1:0]     mem_data_reg;
  logic [WORD_W-1:0]     alu_result_reg;
  logic [REG_ADDR_W-1:0] rd_addr_reg;
  logic [WORD_W-1:0]     ise_reg;

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      reg_w_reg      <= 1'b0;
      mem_to_reg_reg <= 1'b0;
      mem_data_reg   <= '0;
      alu_result_reg <= '0;
      rd_addr_reg    <= '0;
      ise_reg        <= '0;
    end else begin
      reg_w_reg      <= Reg_w_in;
      mem_to_reg_reg <= Mem_to_reg_in;
      // Read data is sampled before the same-edge write lands, giving
      // read-before-write for a combined load/store. Non-loads carry 0.
      mem_data_reg   <= Mem_to_reg_in ? rd_word : '0;
      alu_result_reg <= ALU_Result_in;
      rd_addr_reg    <= RdAddr_in;
      ise_reg        <= ISE_in;
    end
  end

  assign Reg_w_out      = reg_w_reg;
  assign Mem_to_reg_out = mem_to_reg_reg;
  assign Mem_Data_out   = mem_data_reg;
  assign ALU_Result_out = alu_result_reg;
  assign RdAddr_out     = rd_addr_reg;
  assign ISE_out        = ise_reg;
  assign Wb_Data        = mem_to_reg_reg ? mem_data_reg : alu_result_reg;

endmodule
